sram_port_arbiter: RTL and testbench

SRAM_PORT_ARBITER -- requirements
Module: sram_port_arbiter

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_port_arbiter_if.sv | 56 +++++
 rtl/rr_arbiter2.sv | 41 ++++
 rtl/sram_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_port_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM port arbiter slice.
// Holds the default bus geometry and the read-tag type that travels
// down the read-return pipeline alongside each SRAM port-0 read.
package sram_ctrl_pkg;

    localparam int ADDR_WIDTH = 8;   // word address bits
    localparam int DATA_WIDTH = 32;  // data bits
    localparam int NUM_WMASKS = 4;   // byte-lane write mask bits

    // One in-flight port-0 read: valid marks a read, id names the requester.
    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bundle of every non-clock/reset signal of sram_port_arbiter.
// slave  : arbiter side (takes requests, drives the SRAM macro pins).
// master : environment side (requesters, port-1 reader, SRAM macro model).
interface sram_port_arbiter_if #(
    parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS
);
    logic                  req0_valid, req0_ready, req0_we, req0_rvalid;
    logic [NUM_WMASKS-1:0] req0_wmask;
    logic [ADDR_WIDTH-1:0] req0_addr;
    logic [DATA_WIDTH-1:0] req0_wdata, req0_rdata;
    logic                  req1_valid, req1_ready, req1_we, req1_rvalid;
    logic [NUM_WMASKS-1:0] req1_wmask;
    logic [ADDR_WIDTH-1:0] req1_addr;
    logic [DATA_WIDTH-1:0] req1_wdata, req1_rdata;
    logic                  rd_valid, rd_rvalid;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  sram_csb0, sram_web0, sram_csb1;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_WIDTH-1:0] sram_addr0, sram_addr1;
    logic [DATA_WIDTH-1:0] sram_din0, sram_dout0, sram_dout1;
    logic                  collision, collision_clr;

    modport slave (
        input  req0_valid, req0_we, req0_wmask, req0_addr, req0_wdata,
        output req0_ready, req0_rvalid, req0_rdata,
        input  req1_valid, req1_we, req1_wmask, req1_addr, req1_wdata,
        output req1_ready, req1_rvalid, req1_rdata,
        input  rd_valid, rd_addr,
        output rd_rvalid, rd_rdata,
        output sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        input  sram_dout0,
        output sram_csb1, sram_addr1,
        input  sram_dout1,
        output collision,
        input  collision_clr
    );

    modport master (
        output req0_valid, req0_we, req0_wmask, req0_addr, req0_wdata,
        input  req0_ready, req0_rvalid, req0_rdata,
        output req1_valid, req1_we, req1_wmask, req1_addr, req1_wdata,
        input  req1_ready, req1_rvalid, req1_rdata,
        output rd_valid, rd_addr,
        input  rd_rvalid, rd_rdata,
        input  sram_csb0, sram_web0, sram_wmask0, sram_addr0, sram_din0,
        output sram_dout0,
        input  sram_csb1, sram_addr1,
        output sram_dout1,
        input  collision,
        output collision_clr
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin selector.
// Ports: clk_i/rst_i (sync active-high), req_i[1:0] request vector,
//        gnt_o[1:0] one-hot (or zero) combinational grant.
// A lone request is granted; on a tie the requester not granted most
// recently wins. Reset makes requester 0 win the first tie.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic last_q;  // 1: requester 1 was granted most recently
    logic last_d;

    // Grant decode and pointer update; any request is accepted the same cycle.
    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
        if (req_i != 2'b00) begin
            last_d = gnt_o[1];
        end else begin
            last_d = last_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Arbitrates two requesters onto SRAM port 0 (read/write) and passes a
// single reader through to SRAM port 1 (read only).
// Ports: wb_clk_i clock, wb_rst_i sync active-high reset, bus (slave
// modport): req0_*/req1_* requester handshakes and read returns, rd_*
// port-1 reader, sram_* macro pins, collision sticky flag + clear.
// Reads return two edges after acceptance; a tag pipeline routes each
// returning word to the requester that issued it.
module sram_port_arbiter
    import sram_ctrl_pkg::tag_t;
#(
    parameter int ADDR_WIDTH = sram_ctrl_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = sram_ctrl_pkg::DATA_WIDTH,
    parameter int NUM_WMASKS = sram_ctrl_pkg::NUM_WMASKS
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    sram_port_arbiter_if.slave    bus
);
    logic [1:0]            req_s, gnt_s;
    logic                  ready0_s, ready1_s, accept_s, sel_we_s, coll_set_s;
    logic [NUM_WMASKS-1:0] sel_wmask_s;
    logic [ADDR_WIDTH-1:0] sel_addr_s;
    logic [DATA_WIDTH-1:0] sel_wdata_s;

    logic                  csb0_q, csb0_d, web0_q, web0_d, csb1_q, csb1_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    tag_t                  tag_p1_q, tag_p1_d, tag_p2_q, tag_p2_d;
    logic                  rd_p1_q, rd_p1_d, rd_p2_q, rd_p2_d;
    logic                  rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                  rd_rvalid_q, rd_rvalid_d, collision_q, collision_d;
    logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [DATA_WIDTH-1:0] rd_rdata_q, rd_rdata_d;

    assign req_s = {bus.req1_valid, bus.req0_valid};

    rr_arbiter2 u_rr (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .req_i (req_s),
        .gnt_o (gnt_s)
    );

    // Nothing is accepted while reset is asserted.
    assign ready0_s = bus.req0_valid & gnt_s[0] & ~wb_rst_i;
    assign ready1_s = bus.req1_valid & gnt_s[1] & ~wb_rst_i;
    assign accept_s = ready0_s | ready1_s;

    // Steer the accepted requester's command onto the port-0 path.
    always_comb begin
        if (ready1_s) begin
            sel_we_s    = bus.req1_we;
            sel_wmask_s = bus.req1_wmask;
            sel_addr_s  = bus.req1_addr;
            sel_wdata_s = bus.req1_wdata;
        end else begin
            sel_we_s    = bus.req0_we;
            sel_wmask_s = bus.req0_wmask;
            sel_addr_s  = bus.req0_addr;
            sel_wdata_s = bus.req0_wdata;
        end
    end

    assign coll_set_s = accept_s & sel_we_s & bus.rd_valid & (sel_addr_s == bus.rd_addr);

    // Next-state for SRAM pins, read pipelines, return data and collision flag.
    always_comb begin
        csb0_d   = 1'b1;
        web0_d   = web0_q;
        wmask0_d = wmask0_q;
        addr0_d  = addr0_q;
        din0_d   = din0_q;
        if (accept_s) begin
            csb0_d   = 1'b0;
            web0_d   = ~sel_we_s;
            wmask0_d = sel_wmask_s;
            addr0_d  = sel_addr_s;
            din0_d   = sel_wdata_s;
        end else begin
            csb0_d   = 1'b1;
        end

        tag_p1_d.valid = accept_s & ~sel_we_s;
        tag_p1_d.id    = ready1_s;
        tag_p2_d       = tag_p1_q;
        // Stage 2 lines up with sram_dout0 being valid for that read.
        rvalid0_d = tag_p2_q.valid & ~tag_p2_q.id;
        rvalid1_d = tag_p2_q.valid &  tag_p2_q.id;
        rdata0_d  = rvalid0_d ? bus.sram_dout0 : rdata0_q;
        rdata1_d  = rvalid1_d ? bus.sram_dout0 : rdata1_q;

        csb1_d      = ~bus.rd_valid;
        addr1_d     = bus.rd_valid ? bus.rd_addr : addr1_q;
        rd_p1_d     = bus.rd_valid;
        rd_p2_d     = rd_p1_q;
        rd_rvalid_d = rd_p2_q;
        rd_rdata_d  = rd_p2_q ? bus.sram_dout1 : rd_rdata_q;

        // A new collision outranks a simultaneous clear.
        if (coll_set_s) begin
            collision_d = 1'b1;
        end else if (bus.collision_clr) begin
            collision_d = 1'b0;
        end else begin
            collision_d = collision_q;
        end
    end

    // State registers with synchronous reset; in-flight reads are dropped.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            csb0_q      <= 1'b1;
            web0_q      <= 1'b1;
            wmask0_q    <= '0;
            addr0_q     <= '0;
            din0_q      <= '0;
            csb1_q      <= 1'b1;
            addr1_q     <= '0;
            tag_p1_q    <= '0;
            tag_p2_q    <= '0;
            rd_p1_q     <= 1'b0;
            rd_p2_q     <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rd_rvalid_q <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            rd_rdata_q  <= '0;
            collision_q <= 1'b0;
        end else begin
            csb0_q      <= csb0_d;
            web0_q      <= web0_d;
            wmask0_q    <= wmask0_d;
            addr0_q     <= addr0_d;
            din0_q      <= din0_d;
            csb1_q      <= csb1_d;
            addr1_q     <= addr1_d;
            tag_p1_q    <= tag_p1_d;
            tag_p2_q    <= tag_p2_d;
            rd_p1_q     <= rd_p1_d;
            rd_p2_q     <= rd_p2_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rd_rvalid_q <= rd_rvalid_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            rd_rdata_q  <= rd_rdata_d;
            collision_q <= collision_d;
        end
    end

    assign bus.req0_ready  = ready0_s;
    assign bus.req1_ready  = ready1_s;
    assign bus.req0_rvalid = rvalid0_q;
    assign bus.req1_rvalid = rvalid1_q;
    assign bus.req0_rdata  = rdata0_q;
    assign bus.req1_rdata  = rdata1_q;
    assign bus.rd_rvalid   = rd_rvalid_q;
    assign bus.rd_rdata    = rd_rdata_q;
    assign bus.sram_csb0   = csb0_q;
    assign bus.sram_web0   = web0_q;
    assign bus.sram_wmask0 = wmask0_q;
    assign bus.sram_addr0  = addr0_q;
    assign bus.sram_din0   = din0_q;
    assign bus.sram_csb1   = csb1_q;
    assign bus.sram_addr1  = addr1_q;
    assign bus.collision   = collision_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural dual-port SRAM.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sram_port_arbiter_if bus ();

    sram_port_arbiter dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .bus      (bus.slave)
    );

    // Behavioural SRAM: registered read data, read-before-write on the
    // other port. Two words are preloaded for the contention test.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (rst) begin
            mem[1] <= 32'h1111_AAAA;
            mem[2] <= 32'h2222_BBBB;
        end else begin
            if (!bus.sram_csb0) begin
                if (!bus.sram_web0) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.sram_wmask0[b]) mem[bus.sram_addr0][8*b +: 8] <= bus.sram_din0[8*b +: 8];
                    end
                end else begin
                    bus.sram_dout0 <= mem[bus.sram_addr0];
                end
            end
            if (!bus.sram_csb1) bus.sram_dout1 <= mem[bus.sram_addr1];
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Write through requester 0 and check the registered port-0 command.
    task automatic wr0(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
        bus.req0_valid = 1'b1; bus.req0_we = 1'b1;
        bus.req0_addr = a; bus.req0_wdata = d; bus.req0_wmask = m;
        #1 chk("wr_ready0", {31'd0, bus.req0_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        chk("wr_csb0", {31'd0, bus.sram_csb0}, 32'd0);
        chk("wr_web0", {31'd0, bus.sram_web0}, 32'd0);
        chk("wr_wmask0", {28'd0, bus.sram_wmask0}, {28'd0, m});
        chk("wr_addr0", {24'd0, bus.sram_addr0}, {24'd0, a});
        chk("wr_din0", bus.sram_din0, d);
        @(posedge clk); #1;
        chk("idle_csb0", {31'd0, bus.sram_csb0}, 32'd1);
    endtask

    // Read through requester 0; data must appear only after the second edge.
    task automatic rd0(input logic [7:0] a, input logic [31:0] exp);
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = a;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        chk("rd_web0", {31'd0, bus.sram_web0}, 32'd1);
        @(posedge clk); #1;
        chk("rd_early_rvalid0", {31'd0, bus.req0_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("rd_rvalid0", {31'd0, bus.req0_rvalid}, 32'd1);
        chk("rd_rvalid1_quiet", {31'd0, bus.req1_rvalid}, 32'd0);
        chk("rd_rdata0", bus.req0_rdata, exp);
        @(posedge clk); #1;
        chk("rd_pulse_end", {31'd0, bus.req0_rvalid}, 32'd0);
        chk("rd_hold", bus.req0_rdata, exp);
    endtask

    initial begin
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h01;
        bus.req0_wdata = 32'd0; bus.req0_wmask = 4'h0;
        bus.req1_valid = 1'b1; bus.req1_we = 1'b0; bus.req1_addr = 8'h02;
        bus.req1_wdata = 32'd0; bus.req1_wmask = 4'h0;
        bus.rd_valid = 1'b0; bus.rd_addr = 8'h00; bus.collision_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
        chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
        chk("rst_csb0", {31'd0, bus.sram_csb0}, 32'd1);
        chk("rst_web0", {31'd0, bus.sram_web0}, 32'd1);
        chk("rst_csb1", {31'd0, bus.sram_csb1}, 32'd1);
        chk("rst_wmask0", {28'd0, bus.sram_wmask0}, 32'd0);
        chk("rst_addr0", {24'd0, bus.sram_addr0}, 32'd0);
        chk("rst_din0", bus.sram_din0, 32'd0);
        chk("rst_rvalid", {29'd0, bus.req0_rvalid, bus.req1_rvalid, bus.rd_rvalid}, 32'd0);
        chk("rst_rdata0", bus.req0_rdata, 32'd0);
        chk("rst_collision", {31'd0, bus.collision}, 32'd0);

        // Contention: both read continuously for six accepts.
        rst = 1'b0;
        #1;
        for (int j = 0; j < 10; j++) begin
            if (j < 6) begin
                chk("cont_ready0", {31'd0, bus.req0_ready}, (j % 2 == 0) ? 32'd1 : 32'd0);
                chk("cont_ready1", {31'd0, bus.req1_ready}, (j % 2 == 1) ? 32'd1 : 32'd0);
            end
            if (j >= 3 && j < 9) begin
                chk("cont_rvalid0", {31'd0, bus.req0_rvalid}, ((j - 3) % 2 == 0) ? 32'd1 : 32'd0);
                chk("cont_rvalid1", {31'd0, bus.req1_rvalid}, ((j - 3) % 2 == 1) ? 32'd1 : 32'd0);
                if ((j - 3) % 2 == 0) chk("cont_rdata0", bus.req0_rdata, 32'h1111_AAAA);
                else                  chk("cont_rdata1", bus.req1_rdata, 32'h2222_BBBB);
            end else begin
                chk("cont_no_rvalid", {30'd0, bus.req0_rvalid, bus.req1_rvalid}, 32'd0);
            end
            @(negedge clk);
            if (j == 5) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
        end

        // Write-then-read, byte-masked write, zero-mask write.
        wr0(8'h10, 32'hDEAD_BEEF, 4'hF);
        rd0(8'h10, 32'hDEAD_BEEF);
        wr0(8'h10, 32'h1122_3344, 4'h5);
        rd0(8'h10, 32'hDE22_BE44);
        wr0(8'h10, 32'h0000_0000, 4'h0);
        rd0(8'h10, 32'hDE22_BE44);

        // Port 1 read of 0x10 in the same cycle requester 1 writes 0x10.
        bus.req1_valid = 1'b1; bus.req1_we = 1'b1; bus.req1_addr = 8'h10;
        bus.req1_wdata = 32'h5566_7788; bus.req1_wmask = 4'hF;
        bus.rd_valid = 1'b1; bus.rd_addr = 8'h10;
        #1 chk("p1_ready1", {31'd0, bus.req1_ready}, 32'd1);
        @(posedge clk); #1;
        bus.req1_valid = 1'b0; bus.rd_valid = 1'b0;
        chk("p1_collision", {31'd0, bus.collision}, 32'd1);
        chk("p1_csb1", {31'd0, bus.sram_csb1}, 32'd0);
        chk("p1_addr1", {24'd0, bus.sram_addr1}, 32'h10);
        @(posedge clk); #1;
        chk("p1_early_rvalid", {31'd0, bus.rd_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("p1_rvalid", {31'd0, bus.rd_rvalid}, 32'd1);
        // The model returns the pre-write word for a same-edge read.
        chk("p1_rdata", bus.rd_rdata, 32'hDE22_BE44);
        chk("p1_wr_no_rvalid1", {31'd0, bus.req1_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("p1_pulse_end", {31'd0, bus.rd_rvalid}, 32'd0);
        chk("p1_hold", bus.rd_rdata, 32'hDE22_BE44);
        chk("coll_sticky", {31'd0, bus.collision}, 32'd1);
        bus.collision_clr = 1'b1;
        @(posedge clk); #1;
        bus.collision_clr = 1'b0;
        chk("coll_cleared", {31'd0, bus.collision}, 32'd0);

        // Different addresses: no collision.
        bus.req1_valid = 1'b1; bus.req1_wmask = 4'h0; bus.rd_valid = 1'b1; bus.rd_addr = 8'h11;
        @(posedge clk); #1;
        chk("coll_diff_addr", {31'd0, bus.collision}, 32'd0);
        // Set wins over a simultaneous clear.
        bus.rd_addr = 8'h10; bus.collision_clr = 1'b1;
        @(posedge clk); #1;
        bus.req1_valid = 1'b0; bus.rd_valid = 1'b0; bus.collision_clr = 1'b0;
        chk("coll_set_wins", {31'd0, bus.collision}, 32'd1);
        @(posedge clk); #1;
        rd0(8'h10, 32'h5566_7788);

        // Reset at E1 of a read: nothing returns, flag cleared, tie to 0.
        bus.req0_valid = 1'b1; bus.req0_we = 1'b0; bus.req0_addr = 8'h10;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mr_csb0", {31'd0, bus.sram_csb0}, 32'd1);
        chk("mr_collision", {31'd0, bus.collision}, 32'd0);
        chk("mr_rvalid_a", {31'd0, bus.req0_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("mr_rvalid_b", {31'd0, bus.req0_rvalid}, 32'd0);
        @(posedge clk); #1;
        chk("mr_rvalid_c", {31'd0, bus.req0_rvalid}, 32'd0);
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1; bus.req1_we = 1'b0;
        #1;
        chk("mr_tie_ready0", {31'd0, bus.req0_ready}, 32'd1);
        chk("mr_tie_ready1", {31'd0, bus.req1_ready}, 32'd0);
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
